// File: rtl/display_pkg.sv
// Shared types and constants for the registered score display.
package display_pkg;

   localparam logic [3:0] BLANK_CODE = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < n; i++) r = r * 32'd10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Iterative double-dabble converter: one input bit per clock, saturating to all 9s
// when the captured value does not fit in DIGITS decimal digits.
//
// state | meaning
// IDLE  | waiting for a load; outputs hold the last result
// SHIFT | WIDTH add-3/shift steps on {scratch, bin}
// DONE  | latch bcd/overflow, pulse valid for one cycle
module bcd_seq_conv
   import display_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [WIDTH-1:0]      i_bin,
   output logic                  o_busy,
   output logic                  o_valid,
   output logic                  o_overflow,
   output logic [4*DIGITS-1:0]   o_bcd
);

   localparam int          CW    = $clog2(WIDTH);
   localparam logic [31:0] LIMIT = pow10(DIGITS);

   conv_state_t           r_state;
   logic [WIDTH-1:0]      r_bin;
   logic [4*DIGITS-1:0]   r_scr;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf_cap;

   logic [4*DIGITS-1:0]   w_adj;
   logic                  w_ovf;

   always_comb begin
      w_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
         else                         w_adj[4*i +: 4] = r_scr[4*i +: 4];
      end
   end

   assign w_ovf = (32'(i_bin) >= LIMIT);

   // o_busy reflects the state seen at the previous edge, so it stays high through the
   // valid cycle and also masks a load arriving in that cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_scr      <= '0;
         r_cnt      <= '0;
         r_ovf_cap  <= 1'b0;
         o_busy     <= 1'b0;
         o_valid    <= 1'b0;
         o_overflow <= 1'b0;
         o_bcd      <= '0;
      end else begin
         o_valid <= 1'b0;
         o_busy  <= (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (i_load && !o_busy) begin
                  r_bin     <= i_bin;
                  r_scr     <= '0;
                  r_ovf_cap <= w_ovf;
                  r_cnt     <= CW'(WIDTH - 1);
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               {r_scr, r_bin} <= {w_adj, r_bin} << 1;
               r_cnt          <= r_cnt - 1'b1;
               if (r_cnt == '0) r_state <= DONE;
            end
            DONE: begin
               o_bcd      <= r_ovf_cap ? {DIGITS{4'h9}} : r_scr;
               o_overflow <= r_ovf_cap;
               o_valid    <= 1'b1;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/hexa7seg.sv
// Digit code to active-low seven-segment pattern, bit 0 = segment a ... bit 6 = segment g.
// Codes 0-9 draw the digit; every other code (including BLANK_CODE) turns all segments off.
module hexa7seg (
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'b1111111;
      case (i_code)
         4'd0: o_seg = 7'b1000000;
         4'd1: o_seg = 7'b1111001;
         4'd2: o_seg = 7'b0100100;
         4'd3: o_seg = 7'b0110000;
         4'd4: o_seg = 7'b0011001;
         4'd5: o_seg = 7'b0010010;
         4'd6: o_seg = 7'b0000010;
         4'd7: o_seg = 7'b1111000;
         4'd8: o_seg = 7'b0000000;
         4'd9: o_seg = 7'b0010000;
         default: o_seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/display_pontos_seq.sv
// Registered score display: sequential BCD conversion, leading-zero blanking,
// global enable and a free-running blink phase driving one hexa7seg per digit.
module display_pontos_seq
   import display_pkg::*;
#(
   parameter int WIDTH     = 14,
   parameter int DIGITS    = 4,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      pontos,
   input  logic                  load,
   input  logic                  enable,
   input  logic                  blank_zeros,
   input  logic                  blink,
   output logic                  busy,
   output logic                  valid,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   disp
);

   localparam int BW = $clog2(BLINK_DIV);

   logic [BW-1:0]             r_blink_cnt;
   logic                      r_phase;
   logic [DIGITS-1:0][3:0]    w_code;

   bcd_seq_conv #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_conv (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_load     (load),
      .i_bin      (pontos),
      .o_busy     (busy),
      .o_valid    (valid),
      .o_overflow (overflow),
      .o_bcd      (bcd)
   );

   // Free-running, independent of blink, so re-enabling blink keeps the same cadence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   always_comb begin
      logic v_zero_run;
      v_zero_run = 1'b1;
      w_code     = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_zero_run = v_zero_run && (bcd[4*i +: 4] == 4'd0);
         if (!enable || (blink && r_phase))        w_code[i] = BLANK_CODE;
         else if (blank_zeros && i > 0 && v_zero_run) w_code[i] = BLANK_CODE;
         else                                      w_code[i] = bcd[4*i +: 4];
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      hexa7seg u_seg (
         .i_code (w_code[g]),
         .o_seg  (disp[7*g +: 7])
      );
   end

endmodule

// File: tb/tb_display_pontos_seq.sv
// Self-checking bench for display_pontos_seq against a decimal-arithmetic reference model.
module tb_display_pontos_seq;

   localparam int W  = 14;
   localparam int D  = 4;
   localparam int BD = 4;

   localparam logic [6:0] SEG [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic           clk;
   logic           reset;
   logic [W-1:0]   pontos;
   logic           load;
   logic           enable;
   logic           blank_zeros;
   logic           blink;
   logic           busy;
   logic           valid;
   logic           overflow;
   logic [4*D-1:0] bcd;
   logic [7*D-1:0] disp;

   int n_chk = 0;
   int n_bad = 0;
   int n_edge;
   int m_val;
   bit m_ovf;

   display_pontos_seq #(
      .WIDTH     (W),
      .DIGITS    (D),
      .BLINK_DIV (BD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pontos      (pontos),
      .load        (load),
      .enable      (enable),
      .blank_zeros (blank_zeros),
      .blink       (blink),
      .busy        (busy),
      .valid       (valid),
      .overflow    (overflow),
      .bcd         (bcd),
      .disp        (disp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge reset)
      if (reset) n_edge <= 0;
      else       n_edge <= n_edge + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int blink_phase();
      return (n_edge / BD) % 2;
   endfunction

   function automatic logic [4*D-1:0] exp_bcd(input int val);
      logic [4*D-1:0] b;
      int p;
      b = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         b[4*i +: 4] = 4'((val / p) % 10);
         p = p * 10;
      end
      return b;
   endfunction

   function automatic logic [7*D-1:0] exp_disp(input int val, input bit en, input bit bz, input bit ph);
      logic [7*D-1:0] d;
      int p;
      int dig;
      d = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         dig = (val / p) % 10;
         if (!en || ph || (bz && i > 0 && val < p)) d[7*i +: 7] = 7'h7F;
         else                                       d[7*i +: 7] = SEG[dig];
         p = p * 10;
      end
      return d;
   endfunction

   // Converts val; optionally scrambles pontos mid-conversion and fires one extra load
   // at offset extra_k (edges after the accepted load), which must be ignored.
   task automatic run_conv(input int val, input int extra_k, input int extra_val, input bit mess);
      int nb, nv, vat;
      nb = 0; nv = 0; vat = -1;
      @(negedge clk);
      pontos = W'(val);
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k <= W + 4; k++) begin
         if (busy)  nb++;
         if (valid) begin nv++; vat = k; end
         if (k == extra_k) begin
            pontos = W'(extra_val);
            load   = 1'b1;
         end else begin
            load = 1'b0;
            if (mess) pontos = W'($urandom);
         end
         @(negedge clk);
      end
      load = 1'b0;
      m_ovf = (val >= 10000);
      m_val = m_ovf ? 9999 : val;
      check_val($sformatf("busy_cycles v=%0d", val), nb, W + 1);
      check_val($sformatf("valid_at v=%0d", val), vat, W + 1);
      check_val($sformatf("valid_count v=%0d", val), nv, 1);
      check_val($sformatf("bcd v=%0d", val), bcd, exp_bcd(m_val));
      check_val($sformatf("overflow v=%0d", val), overflow, m_ovf);
      check_val($sformatf("disp v=%0d en=%0b bz=%0b", val, enable, blank_zeros), disp,
                exp_disp(m_val, enable, blank_zeros, 1'b0));
   endtask

   initial begin
      int nb, nv, blanks, v;
      reset = 1'b1; pontos = '0; load = 1'b0;
      enable = 1'b1; blank_zeros = 1'b1; blink = 1'b0;
      m_val = 0; m_ovf = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_valid", valid, 1'b0);
      check_val("rst_overflow", overflow, 1'b0);
      check_val("rst_bcd", bcd, '0);
      check_val("rst_disp_bz1", disp, exp_disp(0, 1'b1, 1'b1, 1'b0));
      blank_zeros = 1'b0;
      #1 check_val("rst_disp_bz0", disp, exp_disp(0, 1'b1, 1'b0, 1'b0));
      enable = 1'b0;
      #1 check_val("rst_disp_en0", disp, exp_disp(0, 1'b0, 1'b0, 1'b0));
      enable = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      run_conv(1234, -1, 0, 1'b0);
      blank_zeros = 1'b1;
      run_conv(7, -1, 0, 1'b0);
      blank_zeros = 1'b0;
      #1 check_val("disp7_bz0", disp, exp_disp(7, 1'b1, 1'b0, 1'b0));
      blank_zeros = 1'b1;
      run_conv(0, -1, 0, 1'b0);
      run_conv(16383, -1, 0, 1'b0);
      run_conv(9999, -1, 0, 1'b0);
      run_conv(10000, -1, 0, 1'b0);
      run_conv(42, 1, 99, 1'b0);
      run_conv(99, W + 1, 500, 1'b1);
      run_conv(305, -1, 0, 1'b1);

      for (int r = 0; r < 12; r++) begin
         case ($urandom % 3)
            0:       v = $urandom_range(0, 99);
            1:       v = $urandom_range(0, 9999);
            default: v = $urandom_range(0, 16383);
         endcase
         enable      = 1'($urandom);
         blank_zeros = 1'($urandom);
         run_conv(v, -1, 0, 1'b1);
      end

      enable = 1'b1; blank_zeros = 1'b0;
      run_conv(2468, -1, 0, 1'b0);
      @(negedge clk);
      blink = 1'b1;
      blanks = 0;
      for (int c = 0; c < 16; c++) begin
         #1;
         check_val($sformatf("blink c=%0d", c), disp,
                   exp_disp(m_val, 1'b1, 1'b0, 1'(blink_phase())));
         if (disp == exp_disp(0, 1'b0, 1'b0, 1'b0)) blanks++;
         @(negedge clk);
      end
      check_val("blink_blank_cycles", blanks, 8);
      while (blink_phase() == 0) @(negedge clk);
      blink = 1'b0;
      #1 check_val("blink_off_visible", disp, exp_disp(m_val, 1'b1, 1'b0, 1'b0));
      enable = 1'b0; blink = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1 check_val($sformatf("en0_blink c=%0d", c), disp, exp_disp(m_val, 1'b0, 1'b0, 1'b0));
         @(negedge clk);
      end
      enable = 1'b1; blink = 1'b0; blank_zeros = 1'b1;

      pontos = W'(555);
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("midrst_busy", busy, 1'b0);
      check_val("midrst_valid", valid, 1'b0);
      check_val("midrst_bcd", bcd, '0);
      check_val("midrst_overflow", overflow, 1'b0);
      check_val("midrst_disp", disp, exp_disp(0, 1'b1, 1'b1, 1'b0));
      m_val = 0; m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      nb = 0; nv = 0;
      for (int c = 0; c < W + 6; c++) begin
         if (busy)  nb++;
         if (valid) nv++;
         @(negedge clk);
      end
      check_val("postrst_busy_cycles", nb, 0);
      check_val("postrst_valid_count", nv, 0);
      run_conv(555, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
